// File: rtl/slave_pkg.sv
`default_nettype none
// ============================================================================
// Module   : slave_pkg
// Purpose  : Shared types and default constants for the slave event transmitter
// Revision : 1.0 - initial release
// ============================================================================
package slave_pkg;

  localparam int CLK_HZ          = 25_000_000;
  localparam int DEBOUNCE_CYCLES = 250_000;   // 10 ms at 25 MHz
  localparam int PULSE_CYCLES    = 8;
  localparam int GAP_CYCLES      = 8;
  localparam int MAX_PENDING     = 15;

  // Transmitter FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Larger of two integers, used to size the shared pulse/gap timer
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_filter.sv
`default_nettype none
// ============================================================================
// Module   : debounce_filter
// Purpose  : 2-flop synchroniser, counter-based debouncer and rising-edge
//            strobe for a raw asynchronous push-button input
// Revision : 1.0 - initial release
// ============================================================================
module debounce_filter #(
  parameter int DEBOUNCE_CYCLES = slave_pkg::DEBOUNCE_CYCLES
) (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic i_Raw,
  output logic o_Level,
  output logic o_Rise
);

  import slave_pkg::*;

  localparam int              CW           = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   C_COUNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_db_state;
  logic          r_db_state_q;
  logic [CW-1:0] r_count;

  // Synchronise the button, then accept a new level only after it has
  // differed from the accepted level for DEBOUNCE_CYCLES consecutive cycles
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_sync1      <= 1'b0;
      r_sync2      <= 1'b0;
      r_db_state   <= 1'b0;
      r_db_state_q <= 1'b0;
      r_count      <= '0;
    end else begin
      r_sync1      <= i_Raw;
      r_sync2      <= r_sync1;
      r_db_state_q <= r_db_state;
      if (r_sync2 == r_db_state) begin
        r_count <= '0;
      end else if (r_count == C_COUNT_LAST) begin
        r_db_state <= r_sync2;
        r_count    <= '0;
      end else begin
        r_count <= r_count + CW'(1);
      end
    end
  end

  assign o_Level = r_db_state;
  // One-cycle strobe on press only; releases produce nothing
  assign o_Rise  = r_db_state & ~r_db_state_q;

endmodule
`default_nettype wire

// File: rtl/slave_pulse_tx.sv
`default_nettype none
// ============================================================================
// Module   : slave_pulse_tx
// Purpose  : Debounced push-button event queue; each queued press is sent as
//            one fixed-width high pulse followed by a guaranteed low gap
// Revision : 1.0 - initial release
// ============================================================================
module slave_pulse_tx #(
  parameter  int DEBOUNCE_CYCLES = slave_pkg::DEBOUNCE_CYCLES,
  parameter  int PULSE_CYCLES    = slave_pkg::PULSE_CYCLES,
  parameter  int GAP_CYCLES      = slave_pkg::GAP_CYCLES,
  parameter  int MAX_PENDING     = slave_pkg::MAX_PENDING,
  localparam int PW              = $clog2(MAX_PENDING + 1)
) (
  input  logic          i_Clk,
  input  logic          i_Reset,
  input  logic          i_Switch_1,
  output logic          o_PMOD_1,
  output logic          o_LED_1,
  output logic [PW-1:0] o_Pending,
  output logic          o_Overflow
);

  import slave_pkg::*;

  localparam int            TMAX         = max_int(PULSE_CYCLES, GAP_CYCLES);
  localparam int            TW           = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] C_PULSE_LAST = TW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] C_GAP_LAST   = TW'(GAP_CYCLES - 1);
  localparam logic [PW-1:0] C_PEND_MAX   = PW'(MAX_PENDING);

  logic          w_level;
  logic          w_rise;
  logic          w_press;
  logic          w_start;
  state_t        r_state;
  state_t        w_state_next;
  logic [TW-1:0] r_timer;
  logic [TW-1:0] w_timer_next;
  logic          w_pmod_next;
  logic          w_led_next;
  logic          r_pmod;
  logic          r_led;
  logic [PW-1:0] r_pend;
  logic          r_ovf;

  debounce_filter #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .i_Clk   (i_Clk),
    .i_Reset (i_Reset),
    .i_Raw   (i_Switch_1),
    .o_Level (w_level),
    .o_Rise  (w_rise)
  );

  // A rise strobe only occurs while the debounced level is high
  assign w_press = w_rise & w_level;

  // Queue counter: presses add, pulse starts remove, coincident events cancel
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_pend <= '0;
      r_ovf  <= 1'b0;
    end else begin
      case ({w_press, w_start})
        2'b10: begin
          if (r_pend == C_PEND_MAX) begin
            r_ovf <= 1'b1;
          end else begin
            r_pend <= r_pend + PW'(1);
          end
        end
        2'b01:   r_pend <= r_pend - PW'(1);
        default: ;
      endcase
    end
  end

  // Next state and timer: IDLE -> HIGH for PULSE_CYCLES -> GAP for GAP_CYCLES
  always_comb begin
    w_state_next = r_state;
    w_timer_next = r_timer;
    w_start      = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_pend != '0) begin
          w_state_next = HIGH;
          w_timer_next = C_PULSE_LAST;
          w_start      = 1'b1;
        end
      end
      HIGH: begin
        if (r_timer == '0) begin
          w_state_next = GAP;
          w_timer_next = C_GAP_LAST;
        end else begin
          w_timer_next = r_timer - TW'(1);
        end
      end
      GAP: begin
        if (r_timer == '0) begin
          w_state_next = IDLE;
        end else begin
          w_timer_next = r_timer - TW'(1);
        end
      end
      default: begin
        w_state_next = IDLE;
        w_timer_next = '0;
      end
    endcase
  end

  // Output decode from the next state so outputs register together with it
  always_comb begin
    w_pmod_next = (w_state_next == HIGH);
    w_led_next  = (w_state_next != IDLE);
  end

  // State, timer and registered outputs
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_state <= IDLE;
      r_timer <= '0;
      r_pmod  <= 1'b0;
      r_led   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_timer <= w_timer_next;
      r_pmod  <= w_pmod_next;
      r_led   <= w_led_next;
    end
  end

  assign o_PMOD_1   = r_pmod;
  assign o_LED_1    = r_led;
  assign o_Pending  = r_pend;
  assign o_Overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_slave_pulse_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_slave_pulse_tx
// Purpose  : Self-checking bench for slave_pulse_tx (vector table plus
//            hand-written multi-cycle sequences)
// Revision : 1.0 - initial release
// ============================================================================
module tb_slave_pulse_tx;

  logic       clk = 1'b0;
  logic       rst_m, sw_m, pmod_m, led_m, ovf_m;
  logic [1:0] pend_m;
  logic       rst_f, sw_f, pmod_f, led_f, ovf_f;
  logic [1:0] pend_f;

  int n_checks = 0;
  int n_pass   = 0;

  // Per-edge snapshots of the fast instance; index k = after edge k
  logic f_pm   [0:63];
  logic f_led  [0:63];
  logic f_ovf  [0:63];
  int   f_pend [0:63];

  typedef struct {
    logic       sw;
    logic       rst;
    logic       pmod;
    logic       led;
    logic [1:0] pend;
    logic       ovf;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  // Bench parameter set
  slave_pulse_tx #(
    .DEBOUNCE_CYCLES(4), .PULSE_CYCLES(3), .GAP_CYCLES(2), .MAX_PENDING(3)
  ) u_dut (
    .i_Clk(clk), .i_Reset(rst_m), .i_Switch_1(sw_m),
    .o_PMOD_1(pmod_m), .o_LED_1(led_m), .o_Pending(pend_m), .o_Overflow(ovf_m)
  );

  // Same pulse/gap/queue sizes, 1-cycle debounce so presses can outpace pulses
  slave_pulse_tx #(
    .DEBOUNCE_CYCLES(1), .PULSE_CYCLES(3), .GAP_CYCLES(2), .MAX_PENDING(3)
  ) u_fast (
    .i_Clk(clk), .i_Reset(rst_f), .i_Switch_1(sw_f),
    .o_PMOD_1(pmod_f), .o_LED_1(led_f), .o_Pending(pend_f), .o_Overflow(ovf_f)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic add(input logic sw, input logic rst, input logic pm,
                     input logic led, input logic [1:0] pend, input logic ovf);
    vec_t v;
    v.sw = sw; v.rst = rst; v.pmod = pm; v.led = led; v.pend = pend; v.ovf = ovf;
    vecs.push_back(v);
  endtask

  task automatic reset_fast();
    sw_f  = 1'b0;
    rst_f = 1'b1;
    tick();
    tick();
    rst_f = 1'b0;
  endtask

  // raw[k-1] / rmask[k-1] drive switch / reset for edge k
  task automatic run_fast(input logic [63:0] raw, input logic [63:0] rmask, input int n);
    f_pm[0] = pmod_f; f_led[0] = led_f; f_ovf[0] = ovf_f; f_pend[0] = int'(pend_f);
    for (int k = 1; k <= n; k++) begin
      sw_f  = raw[k-1];
      rst_f = rmask[k-1];
      tick();
      f_pm[k] = pmod_f; f_led[k] = led_f; f_ovf[k] = ovf_f; f_pend[k] = int'(pend_f);
    end
    sw_f  = 1'b0;
    rst_f = 1'b0;
  endtask

  function automatic int count_rises(input int lo, input int hi);
    int c = 0;
    for (int k = lo; k <= hi; k++) if (f_pm[k] && !f_pm[k-1]) c++;
    return c;
  endfunction

  function automatic int nth_rise(input int nth, input int hi);
    int c = 0;
    for (int k = 1; k <= hi; k++) begin
      if (f_pm[k] && !f_pm[k-1]) begin
        c++;
        if (c == nth) return k;
      end
    end
    return -1;
  endfunction

  initial begin
    rst_m = 1'b1; sw_m = 1'b0;
    rst_f = 1'b1; sw_f = 1'b0;

    // Reset state
    add(0, 1, 0, 0, 2'd0, 0);
    add(0, 1, 0, 0, 2'd0, 0);
    // Single press held 20 cycles: pend at edge 7, pulse edges 8-10, gap 11-12
    for (int e = 1; e <= 30; e++)
      add(e <= 20, 0, (e >= 8 && e <= 10), (e >= 8 && e <= 12),
          (e == 7) ? 2'd1 : 2'd0, 0);
    // 3-cycle glitch is filtered out
    for (int e = 1; e <= 15; e++)
      add(e <= 3, 0, 0, 0, 2'd0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      sw_m  = vecs[i].sw;
      rst_m = vecs[i].rst;
      tick();
      chk($sformatf("vec%0d{pmod,led,pend,ovf}", i),
          int'({pmod_m, led_m, pend_m, ovf_m}),
          int'({vecs[i].pmod, vecs[i].led, vecs[i].pend, vecs[i].ovf}));
    end

    // Queueing: presses at edges 1,3,5 -> pulses start at 5, 11, 17
    reset_fast();
    run_fast(64'h15, 64'h0, 24);
    chk("q_rises",      count_rises(1, 24), 3);
    chk("q_rise1",      nth_rise(1, 24), 5);
    chk("q_rise2",      nth_rise(2, 24), 11);
    chk("q_rise3",      nth_rise(3, 24), 17);
    chk("q_high_last",  int'(f_pm[7]), 1);
    chk("q_high_end",   int'(f_pm[8]), 0);
    chk("q_pend8",      f_pend[8], 2);
    chk("q_led21",      int'(f_led[21]), 1);
    chk("q_led22",      int'(f_led[22]), 0);
    chk("q_pend_final", f_pend[24], 0);

    // Simultaneous press and pulse start with pend=1 at edge 11
    reset_fast();
    run_fast(64'h85, 64'h0, 24);
    chk("s_pend10", f_pend[10], 1);
    chk("s_pend11", f_pend[11], 1);
    chk("s_pm10",   int'(f_pm[10]), 0);
    chk("s_pm11",   int'(f_pm[11]), 1);
    chk("s_rise3",  nth_rise(3, 24), 17);
    chk("s_pend17", f_pend[17], 0);
    chk("s_rises",  count_rises(1, 24), 3);
    chk("s_ovf",    int'(f_ovf[24]), 0);

    // Saturation: 6 presses, the last one arrives with pend=3 and is dropped
    reset_fast();
    run_fast(64'h555, 64'h0, 40);
    chk("o_pend10", f_pend[10], 3);
    chk("o_pend11", f_pend[11], 2);
    chk("o_pend12", f_pend[12], 3);
    chk("o_ovf13",  int'(f_ovf[13]), 0);
    chk("o_ovf14",  int'(f_ovf[14]), 1);
    chk("o_pend14", f_pend[14], 3);
    chk("o_rises",  count_rises(1, 40), 5);
    chk("o_rise2",  nth_rise(2, 40), 11);
    chk("o_rise5",  nth_rise(5, 40), 29);
    chk("o_ovf40",  int'(f_ovf[40]), 1);
    chk("o_pend40", f_pend[40], 0);
    rst_f = 1'b1;
    tick();
    rst_f = 1'b0;
    chk("o_ovf_cleared", int'(ovf_f), 0);

    // Reset at edge 12 during the second pulse with pend=2
    reset_fast();
    run_fast(64'h155, 64'h800, 40);
    chk("r_pm11",    int'(f_pm[11]), 1);
    chk("r_pend11",  f_pend[11], 2);
    chk("r_pm12",    int'(f_pm[12]), 0);
    chk("r_led12",   int'(f_led[12]), 0);
    chk("r_pend12",  f_pend[12], 0);
    chk("r_ovf12",   int'(f_ovf[12]), 0);
    chk("r_no_more", count_rises(13, 40), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
